// File: rtl/mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: opcode/func7 match values,
// operation select on func3 and FSM states.
package mdu_pkg;

   localparam logic [6:0] OPC_OP       = 7'h33;
   localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the {hi, lo} working pair: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module mdu_step #(
   parameter int unsigned DW = 32
) (
   input  logic          is_div_i,
   input  logic [DW-1:0] hi_i,
   input  logic [DW-1:0] lo_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] hi_o,
   output logic [DW-1:0] lo_o
);

   logic [DW:0]   sum;
   logic [DW:0]   shifted;
   logic [DW-1:0] diff;
   logic          ge;

   // Multiply: lo holds the unconsumed multiplier bits, the product shifts in from the top.
   assign sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : {(DW+1){1'b0}});

   // Divide: hi is the partial remainder (always < divisor), so the difference fits DW bits.
   assign shifted = {hi_i, lo_i[DW-1]};
   assign ge      = shifted >= {1'b0, b_i};
   assign diff    = shifted[DW-1:0] - b_i;

   always_comb begin
      if (is_div_i) begin
         hi_o = ge ? diff : shifted[DW-1:0];
         lo_o = {lo_i[DW-2:0], ge};
      end else begin
         hi_o = sum[DW:1];
         lo_o = {sum[0], lo_i[DW-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand magnitudes,
// sign fix-up on the final step, single-cycle handling of divide special cases.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic [6:0]    opcode_i,
   input  logic [2:0]    func3_i,
   input  logic [6:0]    func7_i,
   input  logic [DW-1:0] operand_1_i,
   input  logic [DW-1:0] operand_2_i,
   input  logic          flush_i,
   output logic          ready_o,
   output logic          busy_o,
   output logic          valid_o,
   output logic [DW-1:0] result_o
);

   localparam int unsigned CW = $clog2(DW);

   mdu_state_e    state_q, state_d;
   mdu_op_e       op_q, op_d, op_in;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic          neg1_q, neg1_d, neg2_q, neg2_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] result_q, result_d;

   logic            accept, is_div_in, neg1_in, neg2_in, div_zero, overflow;
   logic [DW-1:0]   mag1, mag2, special_res, calc_res, step_hi, step_lo;
   logic [2*DW-1:0] prod, prod_fix;

   assign ready_o  = (state_q == IDLE);
   assign busy_o   = (state_q != IDLE);
   assign valid_o  = valid_q;
   assign result_o = result_q;

   assign accept = start_i & ready_o & (opcode_i == OPC_OP) & (func7_i == FUNC7_MULDIV) &
                   ~flush_i;

   assign op_in     = mdu_op_e'(func3_i);
   assign is_div_in = func3_i[2];
   assign neg1_in   = (op_in inside {MUL, MULH, MULHSU, DIV, REM}) & operand_1_i[DW-1];
   assign neg2_in   = (op_in inside {MUL, MULH, DIV, REM}) & operand_2_i[DW-1];
   assign mag1      = neg1_in ? -operand_1_i : operand_1_i;
   assign mag2      = neg2_in ? -operand_2_i : operand_2_i;

   assign div_zero = is_div_in & (operand_2_i == '0);
   assign overflow = (op_in inside {DIV, REM}) & (operand_1_i == {1'b1, {(DW-1){1'b0}}}) &
                     (operand_2_i == '1);

   // func3[1] separates REM/REMU from DIV/DIVU.
   always_comb begin
      if (div_zero) special_res = func3_i[1] ? operand_1_i : '1;
      else          special_res = func3_i[1] ? '0 : operand_1_i;
   end

   mdu_step #(
      .DW(DW)
   ) u_step (
      .is_div_i (op_q[2]),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (b_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   assign prod     = {step_hi, step_lo};
   assign prod_fix = (neg1_q ^ neg2_q) ? -prod : prod;

   always_comb begin
      calc_res = '0;
      unique case (op_q)
         MUL:                 calc_res = prod_fix[DW-1:0];
         MULH, MULHSU, MULHU: calc_res = prod_fix[2*DW-1:DW];
         DIV, DIVU:           calc_res = (neg1_q ^ neg2_q) ? -step_lo : step_lo;
         REM, REMU:           calc_res = neg1_q ? -step_hi : step_hi;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      valid_d  = 1'b0;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d   = op_in;
               neg1_d = neg1_in;
               neg2_d = neg2_in;
               hi_d   = '0;
               lo_d   = is_div_in ? mag1 : mag2;
               b_d    = is_div_in ? mag2 : mag1;
               cnt_d  = CW'(DW - 1);
               if (div_zero || overflow) begin
                  result_d = special_res;
                  valid_d  = 1'b1;
                  state_d  = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            hi_d = step_hi;
            lo_d = step_lo;
            if (cnt_q == '0) begin
               result_d = calc_res;
               valid_d  = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         state_d  = IDLE;
         valid_d  = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op_q     <= MUL;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         valid_q  <= valid_d;
         result_q <= result_d;
      end
   end

endmodule
